// File: rtl/mult_pkg.sv
// Shared types and widths for the multiplier sequencer and its operand queue.
package mult_pkg;

    localparam int OP_W        = 4;
    localparam int PROD_W      = 8;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_TIMEOUT = 31;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_DRAIN
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } opnd_t;

endpackage

// File: rtl/mult_opq.sv
// Operand FIFO of {A,B} pairs; head is the oldest entry, valid whenever not empty.
module mult_opq
    import mult_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     push,
    input  opnd_t                    din,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output opnd_t                    head
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    opnd_t          mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           push_ok;
    logic           pop_ok;

    assign full    = (level == LVL_FULL);
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; pointers and level alone decide which entries are valid.
    always_ff @(posedge Clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/mult_sequencer.sv
// Feeds queued operand pairs to a 4x4 shift-add multiplier and returns results
// through a valid/ready output register, with a sticky timeout error flag.
module mult_sequencer
    import mult_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic                    In_Valid,
    output logic                    In_Ready,
    input  logic [OP_W-1:0]         In_A,
    input  logic [OP_W-1:0]         In_B,
    output logic                    St,
    output logic [OP_W-1:0]         Multiplicando,
    output logic [OP_W-1:0]         Multiplicador,
    input  logic [PROD_W-1:0]       Produto,
    input  logic                    Done,
    input  logic                    Idle,
    output logic                    Out_Valid,
    input  logic                    Out_Ready,
    output logic [OP_W-1:0]         Out_A,
    output logic [OP_W-1:0]         Out_B,
    output logic [PROD_W-1:0]       Out_Prod,
    output logic                    Err,
    output logic [$clog2(DEPTH):0]  Level
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

    state_t         state;
    logic [TW-1:0]  tmo_cnt;
    opnd_t          in_pair;
    opnd_t          head;
    logic           q_full;
    logic           q_empty;
    logic           tmo_hit;
    logic           pop;
    logic           can_start;

    assign in_pair   = '{a: In_A, b: In_B};
    assign In_Ready  = !q_full;
    assign tmo_hit   = (tmo_cnt == TMO_MAX);
    // Leaving WAIT always consumes the head, whether it produced a result or timed out.
    assign pop       = (state == S_WAIT) && (Done || tmo_hit);
    assign can_start = !q_empty && Idle && (!Out_Valid || Out_Ready);

    mult_opq #(
        .DEPTH (DEPTH)
    ) u_opq (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .push  (In_Valid),
        .din   (in_pair),
        .pop   (pop),
        .full  (q_full),
        .empty (q_empty),
        .level (Level),
        .head  (head)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state         <= S_IDLE;
            tmo_cnt       <= '0;
            St            <= 1'b0;
            Multiplicando <= '0;
            Multiplicador <= '0;
            Out_Valid     <= 1'b0;
            Out_A         <= '0;
            Out_B         <= '0;
            Out_Prod      <= '0;
            Err           <= 1'b0;
        end else begin
            // NOTE: the later non-blocking write wins, so a capture below overrides this clear in the same cycle.
            if (Out_Valid && Out_Ready) begin
                Out_Valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (can_start) begin
                        St            <= 1'b1;
                        Multiplicando <= head.a;
                        Multiplicador <= head.b;
                        state         <= S_START;
                    end
                end

                S_START: begin
                    St      <= 1'b0;
                    tmo_cnt <= '0;
                    state   <= S_WAIT;
                end

                S_WAIT: begin
                    if (Done) begin
                        Out_Valid <= 1'b1;
                        Out_A     <= head.a;
                        Out_B     <= head.b;
                        Out_Prod  <= Produto;
                        state     <= S_DRAIN;
                    end else if (tmo_hit) begin
                        Err   <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                // Hold off until Done has dropped so one Done pulse is captured once.
                S_DRAIN: begin
                    if (!Done && Idle) begin
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer with a behavioural shift-add multiplier model.
module tb_mult_sequencer;

    localparam int TIMEOUT = 31;
    localparam int MUL_N   = 6;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        In_Valid = 1'b0;
    logic        In_Ready;
    logic [3:0]  In_A = '0;
    logic [3:0]  In_B = '0;
    logic        St;
    logic [3:0]  Multiplicando;
    logic [3:0]  Multiplicador;
    logic [7:0]  Produto = '0;
    logic        Done = 1'b0;
    logic        Idle;
    logic        Out_Valid;
    logic        Out_Ready = 1'b1;
    logic [3:0]  Out_A;
    logic [3:0]  Out_B;
    logic [7:0]  Out_Prod;
    logic        Err;
    logic [2:0]  Level;

    int tests = 0;
    int failed = 0;
    int st_count = 0;
    bit never_done = 1'b0;
    logic prev_done = 1'b0;

    mult_sequencer #(
        .DEPTH   (4),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .In_Valid      (In_Valid),
        .In_Ready      (In_Ready),
        .In_A          (In_A),
        .In_B          (In_B),
        .St            (St),
        .Multiplicando (Multiplicando),
        .Multiplicador (Multiplicador),
        .Produto       (Produto),
        .Done          (Done),
        .Idle          (Idle),
        .Out_Valid     (Out_Valid),
        .Out_Ready     (Out_Ready),
        .Out_A         (Out_A),
        .Out_B         (Out_B),
        .Out_Prod      (Out_Prod),
        .Err           (Err),
        .Level         (Level)
    );

    always #5 Clk = ~Clk;

    // Multiplier model: not reset by the sequencer; Done pulses MUL_N cycles after St.
    bit         busy = 1'b0;
    int         cnt = 0;
    logic [7:0] ma = '0;
    logic [7:0] mb = '0;

    assign Idle = !busy && !Done;

    always @(posedge Clk) begin
        Done <= 1'b0;
        if (busy) begin
            if (cnt == 0) begin
                Done    <= 1'b1;
                Produto <= ma * mb;
                busy    <= 1'b0;
            end else begin
                cnt <= cnt - 1;
            end
        end else if (St === 1'b1 && !never_done) begin
            busy <= 1'b1;
            cnt  <= MUL_N - 1;
            ma   <= {4'b0, Multiplicando};
            mb   <= {4'b0, Multiplicador};
        end
    end

    always @(posedge Clk) begin
        if (St === 1'b1) st_count <= st_count + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_wait(input logic [3:0] a, input logic [3:0] b);
        bit ok;
        logic rdy;
        ok = 1'b0;
        In_Valid = 1'b1;
        In_A = a;
        In_B = b;
        for (int i = 0; i < 60; i++) begin
            rdy = In_Ready;
            @(negedge Clk);
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        In_Valid = 1'b0;
        check("push_accept", {31'b0, ok}, 32'd1);
    endtask

    task automatic wait_result(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            prev_done = Done;
            @(negedge Clk);
            if (Out_Valid) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, {31'b0, ok}, 32'd1);
    endtask

    initial begin
        int st_base;
        int gap;
        bit ok;
        bit stable;
        logic [7:0] exp_prod [4];
        logic [3:0] exp_a [4];

        exp_prod = '{8'd6, 8'd12, 8'd20, 8'd30};
        exp_a    = '{4'd2, 4'd3, 4'd4, 4'd5};

        // Reset values
        repeat (2) @(negedge Clk);
        check("rst_st", {31'b0, St}, 32'd0);
        check("rst_out_valid", {31'b0, Out_Valid}, 32'd0);
        check("rst_err", {31'b0, Err}, 32'd0);
        check("rst_level", {29'b0, Level}, 32'd0);
        check("rst_mcand", {28'b0, Multiplicando}, 32'd0);
        check("rst_mplier", {28'b0, Multiplicador}, 32'd0);
        check("rst_out_prod", {24'b0, Out_Prod}, 32'd0);
        check("rst_out_ab", {24'b0, Out_A, Out_B}, 32'd0);
        Rst_n = 1'b1;
        @(negedge Clk);
        check("rst_in_ready", {31'b0, In_Ready}, 32'd1);

        // Single op 3*5 with latency checks
        push_wait(4'd3, 4'd5);
        check("lat_st_low", {31'b0, St}, 32'd0);
        check("lat_level1", {29'b0, Level}, 32'd1);
        @(negedge Clk);
        check("lat_st_high", {31'b0, St}, 32'd1);
        check("st_operands", {24'b0, Multiplicando, Multiplicador}, 32'h35);
        @(negedge Clk);
        check("st_one_cycle", {31'b0, St}, 32'd0);
        wait_result("single_wait");
        check("out_after_done", {31'b0, prev_done}, 32'd1);
        check("single_prod", {24'b0, Out_Prod}, 32'h0F);
        check("single_ab", {24'b0, Out_A, Out_B}, 32'h35);
        check("single_level", {29'b0, Level}, 32'd0);
        check("single_st_count", st_count, 32'd1);
        @(negedge Clk);
        check("single_consumed", {31'b0, Out_Valid}, 32'd0);
        repeat (4) @(negedge Clk);

        // Operand extremes
        push_wait(4'd15, 4'd15);
        wait_result("max_wait");
        check("max_prod", {24'b0, Out_Prod}, 32'hE1);
        repeat (4) @(negedge Clk);
        push_wait(4'd0, 4'd9);
        wait_result("zero_wait");
        check("zero_prod", {24'b0, Out_Prod}, 32'h00);
        check("zero_ab", {24'b0, Out_A, Out_B}, 32'h09);
        repeat (4) @(negedge Clk);

        // Fill and backpressure
        Out_Ready = 1'b0;
        push_wait(4'd1, 4'd2);
        push_wait(4'd2, 4'd3);
        push_wait(4'd3, 4'd4);
        push_wait(4'd4, 4'd5);
        check("fill_level4", {29'b0, Level}, 32'd4);
        check("fill_in_ready0", {31'b0, In_Ready}, 32'd0);
        push_wait(4'd5, 4'd6);
        check("fill_level_after5", {29'b0, Level}, 32'd4);
        check("bp_out_valid", {31'b0, Out_Valid}, 32'd1);
        st_base = st_count;
        stable = 1'b1;
        repeat (20) begin
            @(negedge Clk);
            if (!(Out_Valid === 1'b1 && Out_Prod === 8'd2 && Out_A === 4'd1 && Out_B === 4'd2))
                stable = 1'b0;
        end
        check("bp_held_stable", {31'b0, stable}, 32'd1);
        check("bp_no_second_st", st_count, st_base);
        Out_Ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_result("bp_drain_wait");
            check("bp_order_prod", {24'b0, Out_Prod}, {24'b0, exp_prod[k]});
            check("bp_order_a", {28'b0, Out_A}, {28'b0, exp_a[k]});
        end
        check("bp_level_empty", {29'b0, Level}, 32'd0);
        repeat (4) @(negedge Clk);

        // Timeout: the model ignores St
        never_done = 1'b1;
        push_wait(4'd9, 4'd9);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (St) begin
                ok = 1'b1;
                break;
            end
            @(negedge Clk);
        end
        check("tmo_st_seen", {31'b0, ok}, 32'd1);
        gap = 0;
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge Clk);
            gap++;
            if (Err) begin
                ok = 1'b1;
                break;
            end
        end
        check("tmo_err_set", {31'b0, ok}, 32'd1);
        check("tmo_err_delay", gap, TIMEOUT + 2);
        check("tmo_dropped", {29'b0, Level}, 32'd0);
        check("tmo_no_out", {31'b0, Out_Valid}, 32'd0);
        never_done = 1'b0;
        repeat (2) @(negedge Clk);
        push_wait(4'd2, 4'd7);
        wait_result("tmo_next_wait");
        check("tmo_next_prod", {24'b0, Out_Prod}, 32'h0E);
        check("tmo_err_sticky", {31'b0, Err}, 32'd1);
        repeat (4) @(negedge Clk);

        // Reset while in WAIT with three entries queued
        push_wait(4'd1, 4'd1);
        push_wait(4'd2, 4'd2);
        push_wait(4'd3, 4'd3);
        @(negedge Clk);
        check("midrst_level3", {29'b0, Level}, 32'd3);
        Rst_n = 1'b0;
        #1;
        check("midrst_level", {29'b0, Level}, 32'd0);
        check("midrst_err", {31'b0, Err}, 32'd0);
        check("midrst_st", {31'b0, St}, 32'd0);
        check("midrst_ops", {24'b0, Multiplicando, Multiplicador}, 32'd0);
        check("midrst_out", {19'b0, Out_Valid, Out_A, Out_Prod}, 32'd0);
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        push_wait(4'd6, 4'd7);
        wait_result("postrst_wait");
        check("postrst_prod", {24'b0, Out_Prod}, 32'h2A);
        check("postrst_ab", {24'b0, Out_A, Out_B}, 32'h67);
        check("postrst_err", {31'b0, Err}, 32'd0);
        repeat (4) @(negedge Clk);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
